// File: rtl/ahb_decoder.sv
// ---------------------------------------------------------------------------
// ahb_decoder
// AHB address decoder with a built-in default slave. The upper address
// nibble selects one of three slaves; any other region is claimed by the
// default slave. The default slave answers every active transfer with a
// two-cycle ERROR response, records the failing address and counts errors.
//
// Ports
//   HCLK           bus clock
//   HRESET         asynchronous active-high reset
//   HADDR[31:0]    address-phase address
//   HTRANS[1:0]    transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HREADYIn       bus HREADY from the slave-to-master mux
//   HSELAHBAPB     APB bridge select (combinational)
//   HSELSSRAM      SSRAM select (combinational)
//   HSELMYIP       MYIP select (combinational)
//   HREADYDefault  default-slave HREADY (registered)
//   HRESPDefault   default-slave HRESP, 00 OKAY / 01 ERROR (registered)
//   ErrAddr[31:0]  address of the last transfer answered with ERROR
//   ErrCount[7:0]  saturating count of ERROR responses
// ---------------------------------------------------------------------------
module ahb_decoder #(
   parameter logic [3:0] SSRAM_BASE = 4'h0,
   parameter logic [3:0] MYIP_BASE  = 4'h4,
   parameter logic [3:0] APB_BASE   = 4'h8
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HREADYIn,
   output logic        HSELAHBAPB,
   output logic        HSELSSRAM,
   output logic        HSELMYIP,
   output logic        HREADYDefault,
   output logic [1:0]  HRESPDefault,
   output logic [31:0] ErrAddr,
   output logic [7:0]  ErrCount
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 8;

   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_ERROR   = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ERR1 = 2'b01,
      ERR2 = 2'b10
   } state_t;

   state_t state;

   logic [3:0] region;
   logic       hsel_default;
   logic       trans_active;
   logic       accept;

   // Region decode; the priority chain keeps selects one-hot even if two
   // base parameters are ever configured to the same value.
   assign region = HADDR[31:28];

   always_comb begin
      HSELAHBAPB = 1'b0;
      HSELSSRAM  = 1'b0;
      HSELMYIP   = 1'b0;
      if (region == APB_BASE)
         HSELAHBAPB = 1'b1;
      else if (region == SSRAM_BASE)
         HSELSSRAM = 1'b1;
      else if (region == MYIP_BASE)
         HSELMYIP = 1'b1;
   end

   assign hsel_default = ~(HSELAHBAPB | HSELSSRAM | HSELMYIP);

   // NONSEQ or SEQ; IDLE and BUSY never start an error response.
   assign trans_active = (HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ);

   // Address phase of a default-slave transfer completes on this edge.
   assign accept = HREADYIn & hsel_default & trans_active;

   // Default-slave FSM, error capture and counter; outputs come straight
   // from flops so there is no HADDR/HTRANS -> HREADYDefault path.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state         <= IDLE;
         HREADYDefault <= 1'b1;
         HRESPDefault  <= RESP_OKAY;
         ErrAddr       <= '0;
         ErrCount      <= '0;
      end else begin
         case (state)
            IDLE, ERR2: begin
               if (accept) begin
                  state         <= ERR1;
                  HREADYDefault <= 1'b0;
                  HRESPDefault  <= RESP_ERROR;
                  ErrAddr       <= ADDR_W'(HADDR);
                  if (ErrCount != {CNT_W{1'b1}})
                     ErrCount <= ErrCount + CNT_W'(1);
               end else begin
                  state         <= IDLE;
                  HREADYDefault <= 1'b1;
                  HRESPDefault  <= RESP_OKAY;
               end
            end
            ERR1: begin
               // Second cycle of the ERROR response is unconditional.
               state         <= ERR2;
               HREADYDefault <= 1'b1;
               HRESPDefault  <= RESP_ERROR;
            end
            default: begin
               state         <= IDLE;
               HREADYDefault <= 1'b1;
               HRESPDefault  <= RESP_OKAY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_decoder.sv
// ---------------------------------------------------------------------------
// tb_ahb_decoder
// Self-checking bench for ahb_decoder: a decode vector table, hand-written
// error-response sequences, randomized traffic and reset corner cases, all
// compared against a queue-based model of the expected response cycles.
// ---------------------------------------------------------------------------
module tb_ahb_decoder;

   localparam logic [3:0] SSRAM_B = 4'h0;
   localparam logic [3:0] MYIP_B  = 4'h4;
   localparam logic [3:0] APB_B   = 4'h8;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic        HCLK   = 1'b0;
   logic        HRESET = 1'b0;
   logic [31:0] HADDR  = '0;
   logic [1:0]  HTRANS = '0;
   logic        HREADYIn = 1'b1;
   logic        HSELAHBAPB, HSELSSRAM, HSELMYIP;
   logic        HREADYDefault;
   logic [1:0]  HRESPDefault;
   logic [31:0] ErrAddr;
   logic [7:0]  ErrCount;

   int total = 0;
   int bad   = 0;

   // Model: each queued entry is one upcoming response cycle {ready, resp}.
   logic [2:0]  m_q[$];
   logic [31:0] m_addr;
   logic [7:0]  m_cnt;

   ahb_decoder #(
      .SSRAM_BASE (SSRAM_B),
      .MYIP_BASE  (MYIP_B),
      .APB_BASE   (APB_B)
   ) dut (
      .HCLK          (HCLK),
      .HRESET        (HRESET),
      .HADDR         (HADDR),
      .HTRANS        (HTRANS),
      .HREADYIn      (HREADYIn),
      .HSELAHBAPB    (HSELAHBAPB),
      .HSELSSRAM     (HSELSSRAM),
      .HSELMYIP      (HSELMYIP),
      .HREADYDefault (HREADYDefault),
      .HRESPDefault  (HRESPDefault),
      .ErrAddr       (ErrAddr),
      .ErrCount      (ErrCount)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // {apb, ssram, myip}
   function automatic logic [2:0] ref_sel(input logic [31:0] a);
      logic [3:0] n;
      n = a[31:28];
      if (n == APB_B)   return 3'b100;
      if (n == SSRAM_B) return 3'b010;
      if (n == MYIP_B)  return 3'b001;
      return 3'b000;
   endfunction

   function automatic logic [2:0] cur_out();
      if (m_q.size() > 0) return m_q[0];
      return 3'b100;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_addr = '0;
      m_cnt  = '0;
   endtask

   task automatic chk_now(input string name, input logic rdy, input logic [1:0] resp);
      chk({name, "_hready"}, 32'(HREADYDefault), 32'(rdy));
      chk({name, "_hresp"},  32'(HRESPDefault),  32'(resp));
   endtask

   // One bus cycle: drive at negedge, check, then advance the model over
   // the following rising edge.
   task automatic step(input logic [31:0] a, input logic [1:0] t, input logic r);
      logic [2:0] sel;
      logic [2:0] cur;
      logic       acc;
      @(negedge HCLK);
      HADDR = a; HTRANS = t; HREADYIn = r;
      #1;
      sel = ref_sel(a);
      cur = cur_out();
      chk("hsel",     32'({HSELAHBAPB, HSELSSRAM, HSELMYIP}), 32'(sel));
      chk("hready",   32'(HREADYDefault), 32'(cur[2]));
      chk("hresp",    32'(HRESPDefault),  32'(cur[1:0]));
      chk("erraddr",  ErrAddr,            m_addr);
      chk("errcount", 32'(ErrCount),      32'(m_cnt));
      // A new address phase completes only while the bus is not stalled by
      // the first ERROR cycle.
      acc = r && (sel == 3'b000) && t[1] && cur[2];
      @(posedge HCLK);
      if (m_q.size() > 0) m_q.delete(0);
      if (acc) begin
         m_q.push_back(3'b001);
         m_q.push_back(3'b101);
         m_addr = a;
         if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
   endtask

   task automatic do_reset();
      @(posedge HCLK);
      #2;
      HTRANS = T_IDLE;
      HRESET = 1'b1;
      model_reset();
      @(posedge HCLK);
      #2;
      HRESET = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [1:0]  t;
      logic [2:0]  sel;
   } vec_t;

   vec_t vt[9];

   initial begin
      vt[0] = '{32'h8000_0010, T_NONSEQ, 3'b100};
      vt[1] = '{32'h0000_1234, T_SEQ,    3'b010};
      vt[2] = '{32'h4FFF_FFFC, T_NONSEQ, 3'b001};
      vt[3] = '{32'hC000_0000, T_NONSEQ, 3'b000};
      vt[4] = '{32'hFFFF_FFFF, T_SEQ,    3'b000};
      vt[5] = '{32'h7FFF_FFFF, T_NONSEQ, 3'b000};
      vt[6] = '{32'h9000_0000, T_BUSY,   3'b000};
      vt[7] = '{32'h3000_0000, T_IDLE,   3'b000};
      vt[8] = '{32'h8FFF_FFFF, T_SEQ,    3'b100};

      // Reset state, held asynchronously before any clock edge.
      model_reset();
      #1 HRESET = 1'b1;
      #1;
      chk_now("reset", 1'b1, 2'b00);
      chk("reset_erraddr",  ErrAddr, 32'h0);
      chk("reset_errcount", 32'(ErrCount), 32'h0);
      @(posedge HCLK);
      #2 HRESET = 1'b0;

      // Decode table; HREADYIn low so the default slave never starts.
      for (int i = 0; i < 9; i++) begin
         step(vt[i].a, vt[i].t, 1'b0);
         #1;
         chk("table_sel", 32'({HSELAHBAPB, HSELSSRAM, HSELMYIP}), 32'(vt[i].sel));
      end
      chk_now("table_idle", 1'b1, 2'b00);

      // APB access is not the default slave's business.
      step(32'h8000_0010, T_NONSEQ, 1'b1);
      #1 chk_now("apb_idle", 1'b1, 2'b00);

      // Single unmapped NONSEQ: ERR1 right after acceptance, then ERR2, OKAY.
      step(32'hC000_0000, T_NONSEQ, 1'b1);
      #1 chk_now("err1", 1'b0, 2'b01);
      step(32'h0000_0000, T_IDLE, 1'b1);
      #1 chk_now("err2", 1'b1, 2'b01);
      step(32'h0000_0000, T_IDLE, 1'b1);
      #1 chk_now("okay", 1'b1, 2'b00);
      chk("single_erraddr",  ErrAddr, 32'hC000_0000);
      chk("single_errcount", 32'(ErrCount), 32'd1);

      // Unmapped IDLE and BUSY never produce an error.
      do_reset();
      step(32'hD000_0000, T_IDLE, 1'b1);
      step(32'hD000_0000, T_BUSY, 1'b1);
      step(32'hD000_0000, T_IDLE, 1'b1);
      #1 chk_now("idle_busy", 1'b1, 2'b00);
      chk("idle_busy_count", 32'(ErrCount), 32'd0);

      // Back-to-back errors, second presented during ERR2.
      step(32'hC000_0100, T_NONSEQ, 1'b1);
      step(32'hC000_0100, T_IDLE,   1'b1);
      step(32'hD000_0020, T_NONSEQ, 1'b1);
      #1 chk_now("b2b_err1", 1'b0, 2'b01);
      step(32'h0000_0000, T_IDLE, 1'b1);
      step(32'h0000_0000, T_IDLE, 1'b1);
      step(32'h0000_0000, T_IDLE, 1'b1);
      chk("b2b_errcount", 32'(ErrCount), 32'd2);
      chk("b2b_erraddr",  ErrAddr, 32'hD000_0020);

      // Stalled bus: no acceptance while HREADYIn is low.
      repeat (4) step(32'hE000_0000, T_NONSEQ, 1'b0);
      #1 chk_now("stall", 1'b1, 2'b00);
      chk("stall_count", 32'(ErrCount), 32'd2);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a;
         a = $urandom;
         case ($urandom_range(0, 4))
            0: a[31:28] = APB_B;
            1: a[31:28] = SSRAM_B;
            2: a[31:28] = MYIP_B;
            default: ;
         endcase
         step(a, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      end

      // Asynchronous reset in ERR1 aborts the response immediately.
      do_reset();
      step(32'hC000_0000, T_NONSEQ, 1'b1);
      #1 chk_now("pre_abort", 1'b0, 2'b01);
      #1;
      HTRANS = T_IDLE;
      HRESET = 1'b1;
      #1;
      chk_now("abort", 1'b1, 2'b00);
      chk("abort_errcount", 32'(ErrCount), 32'd0);
      chk("abort_erraddr",  ErrAddr, 32'h0);
      model_reset();
      @(posedge HCLK);
      #2 HRESET = 1'b0;
      step(32'hC000_0004, T_NONSEQ, 1'b1);
      #1 chk_now("fresh_err1", 1'b0, 2'b01);
      step(32'h0000_0000, T_IDLE, 1'b1);
      step(32'h0000_0000, T_IDLE, 1'b1);
      step(32'h0000_0000, T_IDLE, 1'b1);
      chk("fresh_count", 32'(ErrCount), 32'd1);

      // Counter saturation: continuous NONSEQ accepts every other cycle.
      do_reset();
      repeat (516) step(32'hF000_0000, T_NONSEQ, 1'b1);
      chk("sat_pre", 32'(ErrCount), 32'd255);
      repeat (6) step(32'hF000_0000, T_NONSEQ, 1'b1);
      repeat (3) step(32'h0000_0000, T_IDLE, 1'b1);
      chk("sat_errcount", 32'(ErrCount), 32'hFF);
      chk("sat_erraddr",  ErrAddr, 32'hF000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
